i2s_rx: RTL and testbench

- Serial audio receiver: the consuming end of the bit-clock / word-clock link that the design's clock divider drives.
- Takes external BCK, LRCK and SDATA (I2S format: MSB first, one-BCK delay after each LRCK edge, left slot while LRCK low).
- Oversamples all three inputs in the clk domain and deserializes them.
- Presents one left/right sample pair per frame with a single-cycle valid strobe to downstream DSP/playback logic.

---
 rtl/i2s_rx.sv | 142 ++++++++++++++
 tb/tb_i2s_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial audio receiver.
// Oversamples bck/lrck/sdata in the clk domain, deserializes the left and
// right slots (MSB first, one-bck delay after each lrck edge) and presents
// one sample pair per frame.
//
// Output handshake: sample_valid is a one-clk strobe with no ready/backpressure.
// left_data/right_data change only in the cycle sample_valid is high and are
// held stable otherwise, so a consumer may capture them on the strobe or at any
// later time before the next strobe.
module i2s_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bck,
  input  logic             lrck,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             locked,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bck_prev;
  logic                   rise;
  logic                   lrck_smp;
  logic                   sdata_smp;
  logic                   lrck_q;
  logic [1:0]             state;
  logic [CW-1:0]          bitcnt;
  logic [WIDTH-1:0]       shreg;
  logic [WIDTH-1:0]       left_hold;
  logic                   lrck_edge;
  logic                   slot_full;

  assign lrck_edge = (lrck_smp != lrck_q);
  assign slot_full = (bitcnt == CW'(WIDTH));
  assign fsm_state = state;

  // Synchronize the three asynchronous serial inputs into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bck_sync   <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
    end else begin
      bck_sync   <= {bck_sync[SYNC_STAGES-2:0], bck};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
    end
  end

  // Detect the bck rising edge and latch lrck/sdata alongside the strobe so
  // the three stay aligned to the same bck rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bck_prev  <= 1'b0;
      rise      <= 1'b0;
      lrck_smp  <= 1'b0;
      sdata_smp <= 1'b0;
    end else begin
      bck_prev  <= bck_sync[SYNC_STAGES-1];
      rise      <= bck_sync[SYNC_STAGES-1] & ~bck_prev;
      lrck_smp  <= lrck_sync[SYNC_STAGES-1];
      sdata_smp <= sdata_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM: hunt for a left-slot start, shift each slot, publish on the
  // falling lrck edge that ends a complete right slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_HUNT;
      bitcnt       <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      lrck_q       <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        lrck_q <= lrck_smp;
        case (state)
          S_HUNT: begin
            if (lrck_edge && !lrck_smp) begin
              state  <= S_LEFT;
              bitcnt <= '0;
            end
          end
          S_LEFT, S_RIGHT: begin
            if (!lrck_edge) begin
              // Data bit, or padding once the slot already holds WIDTH bits.
              if (!slot_full) begin
                shreg  <= {shreg[WIDTH-2:0], sdata_smp};
                bitcnt <= bitcnt + CW'(1);
              end
            end else if (slot_full && (state == S_LEFT) && lrck_smp) begin
              left_hold <= shreg;
              state     <= S_RIGHT;
              bitcnt    <= '0;
            end else if (slot_full && (state == S_RIGHT) && !lrck_smp) begin
              left_data    <= left_hold;
              right_data   <= shreg;
              sample_valid <= 1'b1;
              locked       <= 1'b1;
              state        <= S_LEFT;
              bitcnt       <= '0;
            end else begin
              // Short slot: drop the frame; a falling edge restarts at once.
              frame_err <= 1'b1;
              locked    <= 1'b0;
              bitcnt    <= '0;
              state     <= lrck_smp ? S_HUNT : S_LEFT;
            end
          end
          default: begin
            state  <= S_HUNT;
            bitcnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: self-checking bench for i2s_rx.
// Directed frame table with hand-written expectations, then randomized
// streams scored against a slot-level reference model.
module tb_i2s_rx;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             bck = 1'b0;
  logic             lrck = 1'b0;
  logic             sdata = 1'b0;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             sample_valid;
  logic             frame_err;
  logic             locked;
  logic [1:0]       fsm_state;

  i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .bck(bck),
    .lrck(lrck),
    .sdata(sdata),
    .left_data(left_data),
    .right_data(right_data),
    .sample_valid(sample_valid),
    .frame_err(frame_err),
    .locked(locked),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt++;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] last_pair = '0;
  int err_seen = 0;
  int exp_err = 0;
  int rise_cyc = 0;
  bit lat_en = 1'b0;
  logic prev_valid = 1'b0;
  int lo_ph = 4;
  int hi_ph = 4;
  logic prev_bit = 1'b0;

  typedef struct {
    logic             lr;
    logic [WIDTH-1:0] val;
    int               nbck;
    logic             pad;
  } slot_t;

  typedef struct {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    int               lb;
    int               rb;
    logic             pad;
    bit               emits;
    bit               err;
  } vec_t;

  slot_t sq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bck period: lrck and the delayed data bit change on the falling bck.
  task automatic drive_period(input logic lr, input logic b, input bit mark);
    bck = 1'b0;
    lrck = lr;
    sdata = prev_bit;
    prev_bit = b;
    repeat (lo_ph) @(negedge clk);
    bck = 1'b1;
    if (mark) rise_cyc = clk_cnt;
    repeat (hi_ph) @(negedge clk);
  endtask

  // The MSB goes out one bck after the lrck change, so a slot of N bck
  // delivers N-1 bits before the next edge; WIDTH bits need N >= WIDTH+1.
  task automatic send_slot(input slot_t s);
    for (int p = 0; p < s.nbck; p++) begin
      drive_period(s.lr, (p < WIDTH) ? s.val[WIDTH-1-p] : s.pad, (p == 0) && (s.lr == 1'b0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bck = 1'b0;
    lrck = 1'b0;
    sdata = 1'b0;
    prev_bit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left_data", left_data, 0);
    check("rst_right_data", right_data, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_locked", locked, 0);
    exp_q.delete();
    last_pair = '0;
    err_seen = 0;
    exp_err = 0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_section(input string name);
    repeat (20) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_err_count"}, err_seen, exp_err);
  endtask

  // ---------------- reference model ----------------
  // Works on whole slots after a reset (lrck seen as 0 before the first slot).
  // A slot is complete when its bck count leaves at least WIDTH bits ahead of
  // the next lrck change. A frame is a complete left slot followed by a
  // complete right slot and is published when the next left slot begins.
  task automatic model_stream();
    logic prev_lr = 1'b0;
    int mode = 0;  // 0 searching for a left start, 1 in left, 2 in right
    logic [WIDTH-1:0] hold = '0;
    bit full;
    for (int j = 0; j < sq.size(); j++) begin
      if (sq[j].lr != prev_lr) begin
        full = (j > 0) && (sq[j-1].nbck - 1 >= WIDTH);
        if (mode == 0) begin
          if (sq[j].lr == 1'b0) mode = 1;
        end else if (mode == 1 && full && sq[j].lr == 1'b1) begin
          hold = sq[j-1].val;
          mode = 2;
        end else if (mode == 2 && full && sq[j].lr == 1'b0) begin
          exp_q.push_back({hold, sq[j-1].val});
          mode = 1;
        end else begin
          exp_err++;
          mode = (sq[j].lr == 1'b0) ? 1 : 0;
        end
      end
      prev_lr = sq[j].lr;
    end
  endtask

  task automatic random_stream(input int nframes, input bit allow_short);
    slot_t s;
    sq.delete();
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < 2; c++) begin
        s.lr = c[0];
        s.val = WIDTH'($urandom);
        s.pad = 1'($urandom_range(0, 1));
        if (allow_short && $urandom_range(0, 4) == 0) s.nbck = $urandom_range(4, WIDTH);
        else s.nbck = $urandom_range(WIDTH + 1, 32);
        sq.push_back(s);
      end
    end
    s.lr = 1'b0; s.val = '0; s.nbck = 20; s.pad = 1'b0;
    sq.push_back(s);
    model_stream();
    for (int i = 0; i < sq.size(); i++) send_slot(sq[i]);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (prev_valid) check("valid_one_cycle", sample_valid, 0);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got %0h expected no pulse", {left_data, right_data});
        end else begin
          last_pair = exp_q.pop_front();
          check("sample_pair", {left_data, right_data}, last_pair);
        end
        check("locked_on_valid", locked, 1);
        if (lat_en) check("valid_latency", clk_cnt - rise_cyc, SYNC + 2);
      end
      if (frame_err) begin
        err_seen++;
        check("locked_drop_on_err", locked, 0);
        check("hold_on_err", {left_data, right_data}, last_pair);
      end
    end
    prev_valid = sample_valid;
  end

  // ---------------- stimulus ----------------
  vec_t tbl[9];

  initial begin
    slot_t s;
    tbl[0] = '{16'hA5C3, 16'h1234, 32, 32, 1'b1, 1'b0, 1'b0};  // hunting, no pulse
    tbl[1] = '{16'hA5C3, 16'h1234, 32, 32, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h8001, 16'h7FFE, 32, 32, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 32, 32, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h00FF, 16'hFF00, 17, 17, 1'b0, 1'b1, 1'b0};  // no padding
    tbl[5] = '{16'h00FF, 16'hFF00, 17, 17, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h1357, 16'h2468, 32, 11, 1'b0, 1'b0, 1'b1};  // right: 10 bits
    tbl[7] = '{16'h9ABC, 16'hDEF0, 32, 32, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{16'h0F0F, 16'hF0F0, 20, 24, 1'b0, 1'b1, 1'b0};

    do_reset();

    // Directed frames, continuous stream.
    lat_en = 1'b1;
    lo_ph = 4;
    hi_ph = 4;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].emits) exp_q.push_back({tbl[i].l, tbl[i].r});
      if (tbl[i].err) exp_err++;
      s = '{1'b0, tbl[i].l, tbl[i].lb, tbl[i].pad};
      send_slot(s);
      s = '{1'b1, tbl[i].r, tbl[i].rb, tbl[i].pad};
      send_slot(s);
      if (i == 0) check("locked_while_hunting", locked, 0);
    end
    // Left slot publishes the last table frame; the right slot is cut by reset.
    s = '{1'b0, 16'h4444, 32, 1'b0};
    send_slot(s);
    s = '{1'b1, 16'h5555, 10, 1'b0};
    send_slot(s);
    end_section("directed");
    check("locked_after_directed", locked, 1);

    // Reset mid right slot; outputs checked at zero inside do_reset.
    do_reset();

    // Minimum bck phases, 50 random full frames.
    lo_ph = 3;
    hi_ph = 3;
    random_stream(50, 1'b0);
    end_section("min_phase");
    check("min_phase_no_err", err_seen, 0);

    do_reset();

    // Mixed random stream with occasional short slots.
    lo_ph = 4;
    hi_ph = 5;
    random_stream(30, 1'b1);
    end_section("mixed");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
